// File: rtl/reg_cmd_driver.sv
// reg_cmd_driver: buffers register commands in a small FIFO, issues the matching
// one-hot control strobe to a 4-bit control register, keeps a golden model of
// the register and checks the register read-back against it.
module reg_cmd_driver #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_data,
    input  logic             cmd_bit,
    output logic             cl,
    output logic             ld,
    output logic             inc,
    output logic             dec,
    output logic             sr,
    output logic             ir,
    output logic             sl,
    output logic             il,
    output logic [3:0]       in,
    input  logic [3:0]       out,
    output logic             busy,
    output logic             cmp_done,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       model,
    output logic             model_valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_CL  = 3'd1;
    localparam logic [2:0] OP_LD  = 3'd2;
    localparam logic [2:0] OP_INC = 3'd3;
    localparam logic [2:0] OP_DEC = 3'd4;
    localparam logic [2:0] OP_SR  = 3'd5;
    localparam logic [2:0] OP_SL  = 3'd6;
    localparam logic [2:0] OP_CHK = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // FIFO storage: entry = {op[2:0], data[3:0], bit}
    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [3:0]       data_q, data_d;
    logic             bit_q, bit_d;

    logic             cl_q, cl_d, ld_q, ld_d, inc_q, inc_d, dec_q, dec_d;
    logic             sr_q, sr_d, sl_q, sl_d, ir_q, ir_d, il_q, il_d;
    logic [3:0]       in_q, in_d;
    logic [3:0]       model_q, model_d;
    logic             model_valid_q, model_valid_d;
    logic             cmp_done_q, cmp_done_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             push_s, pop_s;
    logic [7:0]       head_s;
    logic [2:0]       head_op_s;
    logic [3:0]       head_data_s;
    logic             head_bit_s;
    logic [3:0]       expect_s;

    assign cmd_ready   = (count_q < CW'(DEPTH));
    assign push_s      = cmd_valid && cmd_ready;
    assign pop_s       = (state_q == ST_IDLE) && (count_q != {CW{1'b0}});
    assign head_s      = mem_q[rd_ptr_q];
    assign head_op_s   = head_s[7:5];
    assign head_data_s = head_s[4:1];
    assign head_bit_s  = head_s[0];
    assign expect_s    = (op_q == OP_CHK) ? data_q : model_q;

    assign cl          = cl_q;
    assign ld          = ld_q;
    assign inc         = inc_q;
    assign dec         = dec_q;
    assign sr          = sr_q;
    assign sl          = sl_q;
    assign ir          = ir_q;
    assign il          = il_q;
    assign in          = in_q;
    assign model       = model_q;
    assign model_valid = model_valid_q;
    assign cmp_done    = cmp_done_q;
    assign err         = err_q;
    assign err_cnt     = err_cnt_q;
    assign busy        = (count_q != {CW{1'b0}}) || (state_q != ST_IDLE);

    // FIFO pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^AW)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FSM next state, strobe generation, golden-model update and read-back check
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        data_d        = data_q;
        bit_d         = bit_q;
        cl_d          = 1'b0;
        ld_d          = 1'b0;
        inc_d         = 1'b0;
        dec_d         = 1'b0;
        sr_d          = 1'b0;
        sl_d          = 1'b0;
        in_d          = in_q;
        ir_d          = ir_q;
        il_d          = il_q;
        model_d       = model_q;
        model_valid_d = model_valid_q;
        cmp_done_d    = 1'b0;
        err_d         = err_q;
        err_cnt_d     = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    op_d   = head_op_s;
                    data_d = head_data_s;
                    bit_d  = head_bit_s;
                    // NOP is consumed here and never reaches ISSUE
                    if (head_op_s != OP_NOP) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                    // Strobes are registered so they are high exactly during ISSUE
                    case (head_op_s)
                        OP_CL:  cl_d  = 1'b1;
                        OP_LD:  begin
                            ld_d = 1'b1;
                            in_d = head_data_s;
                        end
                        OP_INC: inc_d = 1'b1;
                        OP_DEC: dec_d = 1'b1;
                        OP_SR:  begin
                            sr_d = 1'b1;
                            ir_d = head_bit_s;
                        end
                        OP_SL:  begin
                            sl_d = 1'b1;
                            il_d = head_bit_s;
                        end
                        default: cl_d = 1'b0;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CHECK;
                // Model follows the register at the same edge the strobe takes effect
                case (op_q)
                    OP_CL:  begin
                        model_d       = 4'd0;
                        model_valid_d = 1'b1;
                    end
                    OP_LD:  begin
                        model_d       = data_q;
                        model_valid_d = 1'b1;
                    end
                    OP_INC: model_d = model_q + 4'd1;
                    OP_DEC: model_d = model_q - 4'd1;
                    OP_SR:  model_d = {bit_q, model_q[3:1]};
                    OP_SL:  model_d = {model_q[2:0], bit_q};
                    default: model_d = model_q;
                endcase
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                // An unsynchronised model is only trusted for explicit CHK values
                if ((op_q == OP_CHK) || model_valid_q) begin
                    cmp_done_d = 1'b1;
                    if (out != expect_s) begin
                        err_d = 1'b1;
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                end else begin
                    cmp_done_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO storage write; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_data, cmd_bit};
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= {AW{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            count_q       <= {CW{1'b0}};
            state_q       <= ST_IDLE;
            op_q          <= OP_NOP;
            data_q        <= 4'd0;
            bit_q         <= 1'b0;
            cl_q          <= 1'b0;
            ld_q          <= 1'b0;
            inc_q         <= 1'b0;
            dec_q         <= 1'b0;
            sr_q          <= 1'b0;
            sl_q          <= 1'b0;
            ir_q          <= 1'b0;
            il_q          <= 1'b0;
            in_q          <= 4'd0;
            model_q       <= 4'd0;
            model_valid_q <= 1'b0;
            cmp_done_q    <= 1'b0;
            err_q         <= 1'b0;
            err_cnt_q     <= {ERR_W{1'b0}};
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            op_q          <= op_d;
            data_q        <= data_d;
            bit_q         <= bit_d;
            cl_q          <= cl_d;
            ld_q          <= ld_d;
            inc_q         <= inc_d;
            dec_q         <= dec_d;
            sr_q          <= sr_d;
            sl_q          <= sl_d;
            ir_q          <= ir_d;
            il_q          <= il_d;
            in_q          <= in_d;
            model_q       <= model_d;
            model_valid_q <= model_valid_d;
            cmp_done_q    <= cmp_done_d;
            err_q         <= err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_reg_cmd_driver.sv
// Bench for reg_cmd_driver: a behavioural 4-bit register answers the strobes,
// and a transaction-level reference predicts strobes and compare results.
module tb_reg_cmd_driver;

    localparam int DEPTH = 4;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [3:0]       cmd_data;
    logic             cmd_bit;
    logic             cl, ld, inc, dec, sr, ir, sl, il;
    logic [3:0]       din;
    logic [3:0]       dout;
    logic             busy, cmp_done, err, model_valid;
    logic [ERR_W-1:0] err_cnt;
    logic [3:0]       model;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cmp_done = 0;

    // Environment: the controlled register, optionally with its output stuck at 0
    logic [3:0] phys_reg = 4'h9;
    logic       force0 = 1'b0;
    assign dout = force0 ? 4'h0 : phys_reg;

    // Reference state, advanced per accepted command
    typedef struct { logic [2:0] op; logic [3:0] d; logic b; } strobe_t;
    typedef struct { logic [3:0] m; logic v; logic [7:0] ec; } cmp_t;
    strobe_t    sq[$];
    cmp_t       cq[$];
    logic [3:0] ref_model = 4'h0;
    logic [3:0] ref_reg   = 4'h9;
    logic       ref_valid = 1'b0;
    logic [7:0] ref_errc  = 8'h00;
    logic       saw_not_ready = 1'b0;

    reg_cmd_driver #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_bit(cmd_bit),
        .cl(cl), .ld(ld), .inc(inc), .dec(dec), .sr(sr), .ir(ir), .sl(sl), .il(il),
        .in(din), .out(dout), .busy(busy), .cmp_done(cmp_done), .err(err),
        .err_cnt(err_cnt), .model(model), .model_valid(model_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Register behaviour driven by the strobes
    always @(posedge clk) begin
        if (cl)       phys_reg <= 4'h0;
        else if (ld)  phys_reg <= din;
        else if (inc) phys_reg <= phys_reg + 4'h1;
        else if (dec) phys_reg <= phys_reg - 4'h1;
        else if (sr)  phys_reg <= {ir, phys_reg[3:1]};
        else if (sl)  phys_reg <= {phys_reg[2:0], il};
    end

    int         mon_n;
    logic [2:0] mon_op;
    strobe_t    mon_s;
    cmp_t       mon_c;

    // Monitor: strobe order/payload and compare results against predictions
    always @(negedge clk) begin
        if (!rst) begin
            mon_n = int'(cl) + int'(ld) + int'(inc) + int'(dec) + int'(sr) + int'(sl);
            check_eq("strobe_onehot", 32'(mon_n <= 1), 32'd1);
            if (mon_n == 1) begin
                mon_op = cl ? 3'd1 : ld ? 3'd2 : inc ? 3'd3 : dec ? 3'd4 : sr ? 3'd5 : 3'd6;
                check_eq("strobe_expected", 32'(sq.size() != 0), 32'd1);
                if (sq.size() != 0) begin
                    mon_s = sq.pop_front();
                    check_eq("strobe_op", 32'(mon_op), 32'(mon_s.op));
                    if (mon_s.op == 3'd2) check_eq("ld_in", 32'(din), 32'(mon_s.d));
                    if (mon_s.op == 3'd5) check_eq("sr_ir", 32'(ir), 32'(mon_s.b));
                    if (mon_s.op == 3'd6) check_eq("sl_il", 32'(il), 32'(mon_s.b));
                end
            end
            if (cmp_done) begin
                n_cmp_done++;
                check_eq("cmp_expected", 32'(cq.size() != 0), 32'd1);
                if (cq.size() != 0) begin
                    mon_c = cq.pop_front();
                    check_eq("cmp_model", 32'(model), 32'(mon_c.m));
                    check_eq("cmp_model_valid", 32'(model_valid), 32'(mon_c.v));
                    check_eq("cmp_err_cnt", 32'(err_cnt), 32'(mon_c.ec));
                    check_eq("cmp_err", 32'(err), 32'(mon_c.ec != 8'h00));
                end
            end
        end
    end

    // Reference: what one accepted command does, from the command semantics
    task automatic predict(input logic [2:0] op, input logic [3:0] d, input logic b);
        logic [3:0] expv;
        logic       cmp;
        case (op)
            3'd1: begin ref_model = 4'h0; ref_reg = 4'h0; ref_valid = 1'b1; end
            3'd2: begin ref_model = d; ref_reg = d; ref_valid = 1'b1; end
            3'd3: begin ref_model = ref_model + 4'h1; ref_reg = ref_reg + 4'h1; end
            3'd4: begin ref_model = ref_model - 4'h1; ref_reg = ref_reg - 4'h1; end
            3'd5: begin ref_model = {b, ref_model[3:1]}; ref_reg = {b, ref_reg[3:1]}; end
            3'd6: begin ref_model = {ref_model[2:0], b}; ref_reg = {ref_reg[2:0], b}; end
            default: ;
        endcase
        if (op != 3'd0 && op != 3'd7) sq.push_back('{op: op, d: d, b: b});
        cmp = (op == 3'd7) || (op != 3'd0 && ref_valid);
        if (cmp) begin
            expv = (op == 3'd7) ? d : ref_model;
            if (expv != (force0 ? 4'h0 : ref_reg) && ref_errc != 8'hFF) ref_errc++;
            cq.push_back('{m: ref_model, v: ref_valid, ec: ref_errc});
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic push(input logic [2:0] op, input logic [3:0] d, input logic b);
        logic ok = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_bit = b;
        for (int t = 0; t < 100; t++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            saw_not_ready = 1'b1;
            @(posedge clk); #1;
        end
        check_eq("push_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        predict(op, d, b);
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        check_eq("drain_idle", 32'(busy), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic check_reset_state();
        check_eq("rst_strobes", 32'({cl, ld, inc, dec, sr, sl}), 32'd0);
        check_eq("rst_in_ir_il", 32'({din, ir, il}), 32'd0);
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_model", 32'({model_valid, model}), 32'd0);
        check_eq("rst_err", 32'({err, err_cnt}), 32'd0);
        check_eq("rst_cmp_done", 32'(cmp_done), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sq.delete(); cq.delete();
        ref_model = 4'h0; ref_valid = 1'b0; ref_errc = 8'h00;
        ref_reg = phys_reg;
    endtask

    initial begin
        logic seen;
        int   base;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'd0; cmd_bit = 1'b0;
        @(posedge clk); #1;
        do_reset();
        check_reset_state();

        // Load then explicit check
        push(3'd2, 4'b1010, 1'b0);
        push(3'd7, 4'b1010, 1'b0);
        drain();
        check_eq("ld_model", 32'(model), 32'hA);
        check_eq("ld_err", 32'(err), 32'd0);

        // Wrap-around in both directions
        push(3'd2, 4'd15, 1'b0);
        push(3'd3, 4'd0, 1'b0);
        push(3'd4, 4'd0, 1'b0);
        push(3'd4, 4'd0, 1'b0);
        drain();
        check_eq("wrap_model", 32'(model), 32'd14);
        check_eq("wrap_err_cnt", 32'(err_cnt), 32'd0);

        // Shifts: 0110 -> SR(1) 1011 -> SL(0) 0110
        push(3'd2, 4'b0110, 1'b0);
        push(3'd5, 4'd0, 1'b1);
        push(3'd6, 4'd0, 1'b0);
        drain();
        check_eq("shift_model", 32'(model), 32'b0110);

        // Back-to-back pushes overrun the 1-per-3-cycle drain and fill the FIFO
        saw_not_ready = 1'b0;
        push(3'd2, 4'd3, 1'b0);
        for (int i = 0; i < 7; i++) push(3'd3, 4'd0, 1'b0);
        check_eq("fifo_full_seen", 32'(saw_not_ready), 32'd1);
        drain();
        check_eq("fill_model", 32'(model), 32'd10);

        // Stuck-at-zero read-back
        force0 = 1'b1;
        push(3'd2, 4'd3, 1'b0);
        push(3'd7, 4'd3, 1'b0);
        drain();
        check_eq("mis_err", 32'(err), 32'd1);
        check_eq("mis_err_cnt", 32'(err_cnt), 32'd2);
        for (int i = 0; i < 300; i++) push(3'd2, 4'd5, 1'b0);
        drain();
        check_eq("sat_err_cnt", 32'(err_cnt), 32'd255);
        force0 = 1'b0;

        // Reset during ISSUE of an INC
        push(3'd2, 4'd7, 1'b0);
        drain();
        push(3'd3, 4'd0, 1'b0);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (inc) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        check_eq("inc_issued", 32'(seen), 32'd1);
        do_reset();
        check_reset_state();
        base = n_cmp_done;
        push(3'd3, 4'd0, 1'b0);
        drain();
        check_eq("no_cmp_unsynced", 32'(n_cmp_done - base), 32'd0);
        check_eq("unsynced_model", 32'(model), 32'd1);

        // Randomised traffic with idle gaps and occasional stuck read-back
        for (int i = 0; i < 250; i++) begin
            push(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 5)) begin @(posedge clk); #1; end
            if ($urandom_range(0, 24) == 0) begin
                drain();
                force0 = ~force0;
            end
        end
        drain();
        check_eq("final_err_cnt", 32'(err_cnt), 32'(ref_errc));
        check_eq("final_model", 32'(model), 32'(ref_model));
        check_eq("final_sq_empty", 32'(sq.size()), 32'd0);
        check_eq("final_cq_empty", 32'(cq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
